clk_div_prog: RTL and testbench

Runtime-programmable synchronous clock divider. It replaces the fixed ripple chain of toggle flip-flops: a single counter in the `clk` domain generates a one-cycle tick enable and a divided square wave. The divisor can be reloaded glitch-free at period boundaries. It feeds display multiplexing, debounce and timing blocks, which use `tick_o` as a clock enable, not as a clock.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_cfg.sv | 66 ++++++
 rtl/clk_div_prog.sv | 104 ++++++++++
 tb/tb_clk_div_prog.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the programmable clock divider family:
//   DIV_W_DFLT       - default divisor / counter width
//   DEFAULT_DIV_DFLT - default divisor loaded at reset
//   div_t            - divisor type at the default width
//   half_floor()     - floor(N/2), the sq_o high threshold
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam int DIV_W_DFLT       = 16;
    localparam int DEFAULT_DIV_DFLT = 32;

    typedef logic [DIV_W_DFLT-1:0] div_t;

    // floor(N/2): sq_o is high once the next count reaches this value
    function automatic int unsigned half_floor(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// ---------------------------------------------------------------------------
// clk_div_cfg
// Shadowed divisor register. A load captures a new divisor into a pending
// slot; the pending value moves into the active divisor only when the owner
// signals a safe point through apply_i, so the active divisor never changes
// mid-period.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   load_i     - one-cycle strobe capturing div_i into the pending slot
//   div_i      - new divisor value
//   apply_i    - safe point: promote pending to active if one is waiting
//   cur_div_o  - divisor currently in effect
//   busy_o     - a pending divisor has not yet been applied
// ---------------------------------------------------------------------------
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = DIV_W_DFLT,
    parameter int RESET_DIV = DEFAULT_DIV_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             apply_i,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             busy_o
);

    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;

    always_comb begin
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        busy_d    = busy_q;
        // Apply uses the value pending before this edge; a coincident load
        // then re-arms busy with the new value, so at most one change per edge.
        if (apply_i && busy_q) begin
            cur_div_d = pend_q;
            busy_d    = 1'b0;
        end
        if (load_i) begin
            pend_d = div_i;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_div_q <= DIV_W'(RESET_DIV);
            pend_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            busy_q    <= busy_d;
        end
    end

    assign cur_div_o = cur_div_q;
    assign busy_o    = busy_q;

endmodule

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable synchronous clock divider. One counter in the clk
// domain produces a one-cycle tick enable (tick_o) every N enabled cycles and
// a divided square wave (sq_o, low floor(N/2) / high ceil(N/2) cycles).
// tick_o is meant as a clock enable for downstream logic, not as a clock.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   en_i        - count enable
//   restart_i   - synchronous phase restart (priority over en_i)
//   div_i       - new divisor N (0 = stopped)
//   div_load_i  - one-cycle strobe capturing div_i
//   div_busy_o  - pending divisor not yet applied
//   cur_div_o   - divisor currently in effect
//   tick_o      - one-cycle pulse per N enabled cycles
//   sq_o        - divided square wave, period N
// ---------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             div_busy_o,
    output logic [DIV_W-1:0] cur_div_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] n_minus_1;
    logic [DIV_W-1:0] half_n;
    logic [DIV_W-1:0] next_cnt;
    logic             stopped;
    logic             at_wrap;
    logic             apply;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    clk_div_cfg #(
        .DIV_W     (DIV_W),
        .RESET_DIV (DEFAULT_DIV)
    ) u_cfg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (div_load_i),
        .div_i     (div_i),
        .apply_i   (apply),
        .cur_div_o (cur_div),
        .busy_o    (div_busy_o)
    );

    always_comb begin
        // N-1 wraps to all-ones for N=0; the stopped branch keeps cnt at 0
        // so that value is never matched while stopped.
        n_minus_1 = cur_div - DIV_W'(1);
        half_n    = DIV_W'(half_floor(32'(cur_div)));
        stopped   = (cur_div == '0);
        at_wrap   = (cnt_q == n_minus_1);
        next_cnt  = at_wrap ? '0 : cnt_q + DIV_W'(1);

        // Safe points for a divisor change: period boundary, idle, stopped,
        // or a phase restart.
        apply = restart_i || !en_i || stopped || at_wrap;

        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (restart_i || stopped) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (en_i) begin
            cnt_d  = next_cnt;
            tick_d = at_wrap;
            sq_d   = (next_cnt >= half_n);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

    assign cur_div_o = cur_div;
    assign tick_o    = tick_q;
    assign sq_o      = sq_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// ---------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog: long directed loops for the default
// divisor and the mid-period reload, a vector table for the multi-cycle
// reload / N=1 / N=0 / enable-gap / restart sequences, and a hand-written
// asynchronous reset sequence.
// ---------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int DIV_W = 16;

    logic             clk;
    logic             reset;
    logic             en_i;
    logic             restart_i;
    logic [DIV_W-1:0] div_i;
    logic             div_load_i;
    logic             div_busy_o;
    logic [DIV_W-1:0] cur_div_o;
    logic             tick_o;
    logic             sq_o;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_prog #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_i),
        .restart_i  (restart_i),
        .div_i      (div_i),
        .div_load_i (div_load_i),
        .div_busy_o (div_busy_o),
        .cur_div_o  (cur_div_o),
        .tick_o     (tick_o),
        .sq_o       (sq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic             en;
        logic             rs;
        logic             ld;
        logic [DIV_W-1:0] div;
        logic             tick;
        logic             sq;
        logic             busy;
        logic [DIV_W-1:0] cur;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic rs, input logic ld, input int dv,
                       input logic tk, input logic sq, input logic bz, input int cu);
        vec_t v;
        v.en = en; v.rs = rs; v.ld = ld; v.div = DIV_W'(dv);
        v.tick = tk; v.sq = sq; v.busy = bz; v.cur = DIV_W'(cu);
        tbl.push_back(v);
    endtask

    initial begin
        //      en rs ld div  tick sq busy cur
        // N=5 -> load 1, apply at wrap; N=1; load 0 -> stopped
        add(1, 0, 1, 1,   0, 0, 1, 5);
        add(1, 0, 0, 0,   0, 1, 1, 5);
        add(1, 0, 0, 0,   0, 1, 1, 5);
        add(1, 0, 0, 0,   0, 1, 1, 5);
        add(1, 0, 0, 0,   1, 0, 0, 1);
        add(1, 0, 0, 0,   1, 1, 0, 1);
        add(1, 0, 0, 0,   1, 1, 0, 1);
        add(1, 0, 1, 0,   1, 1, 1, 1);
        add(1, 0, 0, 0,   1, 1, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0);
        add(1, 0, 0, 0,   0, 0, 0, 0);
        // load 6 while stopped: applies on the next edge
        add(1, 0, 1, 6,   0, 0, 1, 0);
        add(1, 0, 0, 0,   0, 0, 0, 6);
        add(1, 0, 0, 0,   0, 0, 0, 6);
        add(1, 0, 0, 0,   0, 0, 0, 6);
        add(1, 0, 0, 0,   0, 1, 0, 6);
        // en_i low for 7 cycles at cnt=3: hold sq, no tick
        for (int i = 0; i < 7; i++) add(0, 0, 0, 0,   0, 1, 0, 6);
        add(1, 0, 0, 0,   0, 1, 0, 6);
        add(1, 0, 0, 0,   0, 1, 0, 6);
        add(1, 0, 0, 0,   1, 0, 0, 6);
        // load 8 applied at wrap, then restart at cnt=5 with 3 pending
        add(1, 0, 1, 8,   0, 0, 1, 6);
        add(1, 0, 0, 0,   0, 0, 1, 6);
        add(1, 0, 0, 0,   0, 1, 1, 6);
        add(1, 0, 0, 0,   0, 1, 1, 6);
        add(1, 0, 0, 0,   0, 1, 1, 6);
        add(1, 0, 0, 0,   1, 0, 0, 8);
        add(1, 0, 0, 0,   0, 0, 0, 8);
        add(1, 0, 0, 0,   0, 0, 0, 8);
        add(1, 0, 0, 0,   0, 0, 0, 8);
        add(1, 0, 1, 3,   0, 1, 1, 8);
        add(1, 0, 0, 0,   0, 1, 1, 8);
        add(1, 1, 0, 0,   0, 0, 0, 3);
        add(1, 0, 0, 0,   0, 1, 0, 3);
        add(1, 0, 0, 0,   0, 1, 0, 3);
        add(1, 0, 0, 0,   1, 0, 0, 3);
        // load while disabled applies on the next disabled edge
        add(0, 0, 1, 4,   0, 0, 1, 3);
        add(0, 0, 0, 0,   0, 0, 0, 4);
        // two loads back to back: last one wins at the wrap
        add(1, 0, 1, 7,   0, 0, 1, 4);
        add(1, 0, 1, 2,   0, 1, 1, 4);
        add(1, 0, 0, 0,   0, 1, 1, 4);
        add(1, 0, 0, 0,   1, 0, 0, 2);
        add(1, 0, 0, 0,   0, 1, 0, 2);
        add(1, 0, 0, 0,   1, 0, 0, 2);
    end

    initial begin
        reset      = 1'b0;
        en_i       = 1'b0;
        restart_i  = 1'b0;
        div_i      = '0;
        div_load_i = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_tick", tick_o, 0);
        chk("rst_sq", sq_o, 0);
        chk("rst_busy", div_busy_o, 0);
        chk("rst_cur", cur_div_o, 32);

        // Default divisor 32: first tick at edge 32, sq low 16 / high 16
        @(negedge clk);
        reset = 1'b1;
        en_i  = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            chk($sformatf("n32_tick_%0d", k), tick_o, (k % 32) == 0);
            chk($sformatf("n32_sq_%0d", k), sq_o, (k % 32) >= 16);
        end
        chk("n32_cur", cur_div_o, 32);

        // Load 5 at cnt=10, applied only at the cnt=31 wrap
        repeat (10) step();
        div_i      = 16'd5;
        div_load_i = 1'b1;
        step();
        div_load_i = 1'b0;
        div_i      = '0;
        chk("ld5_busy", div_busy_o, 1);
        chk("ld5_cur_old", cur_div_o, 32);
        for (int k = 12; k <= 31; k++) begin
            step();
            chk($sformatf("ld5_wait_busy_%0d", k), div_busy_o, 1);
            chk($sformatf("ld5_wait_tick_%0d", k), tick_o, 0);
        end
        step();
        chk("ld5_wrap_tick", tick_o, 1);
        chk("ld5_wrap_sq", sq_o, 0);
        chk("ld5_wrap_cur", cur_div_o, 5);
        chk("ld5_wrap_busy", div_busy_o, 0);
        for (int j = 1; j <= 10; j++) begin
            step();
            chk($sformatf("n5_tick_%0d", j), tick_o, (j % 5) == 0);
            chk($sformatf("n5_sq_%0d", j), sq_o, (j % 5) >= 2);
        end

        // Table-driven multi-cycle sequences
        foreach (tbl[i]) begin
            en_i       = tbl[i].en;
            restart_i  = tbl[i].rs;
            div_load_i = tbl[i].ld;
            div_i      = tbl[i].div;
            step();
            chk($sformatf("vec%0d_tick", i), tick_o, tbl[i].tick);
            chk($sformatf("vec%0d_sq", i), sq_o, tbl[i].sq);
            chk($sformatf("vec%0d_busy", i), div_busy_o, tbl[i].busy);
            chk($sformatf("vec%0d_cur", i), cur_div_o, tbl[i].cur);
        end
        en_i       = 1'b1;
        restart_i  = 1'b0;
        div_load_i = 1'b0;
        div_i      = '0;

        // Asynchronous reset mid-cycle at cnt=20 (with a load pending)
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int k = 1; k <= 19; k++) step();
        div_i      = 16'd9;
        div_load_i = 1'b1;
        step();
        div_load_i = 1'b0;
        div_i      = '0;
        chk("pre_arst_sq", sq_o, 1);
        chk("pre_arst_busy", div_busy_o, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_tick", tick_o, 0);
        chk("arst_sq", sq_o, 0);
        chk("arst_busy", div_busy_o, 0);
        chk("arst_cur", cur_div_o, 32);

        // Release mid-cycle: the interrupted period is discarded
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("post_arst_tick_%0d", k), tick_o, k == 32);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
